// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART transmit path: parity modes,
//               FSM state encoding and the default bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // 50 MHz system clock at 115200 baud
    localparam int c_DEFAULT_CYCLES_PER_BIT = 434;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with registered occupancy count and
//               show-ahead read data; depth must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : FIFO-buffered UART transmitter, LSB first, runtime parity and
//               stop-bit selection latched per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT,
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               i_CLK,
    input  logic                               i_RESET,
    input  logic                               i_TX_DV,
    input  logic [DATA_BITS-1:0]               i_PARALLEL_DATA,
    output logic                               o_TX_READY,
    input  logic [1:0]                         i_PARITY_MODE,
    input  logic                               i_TWO_STOP,
    output logic                               o_SERIAL_DATA,
    output logic                               o_TX_ACTIVE,
    output logic                               o_TX_DONE,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_FIFO_COUNT
);

    localparam int CYC_W = $clog2(CYCLES_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CYC_W-1:0] c_CYC_LAST  = CYC_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_DATA_LAST = BIT_W'(DATA_BITS - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [CYC_W-1:0]     r_cycle_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic [1:0]           r_par_mode;
    logic                 r_two_stop;
    logic                 r_serial;
    logic                 r_active;
    logic                 r_done;

    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_head;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_par_en;
    logic                 w_par_bit;
    logic                 w_serial;
    logic                 w_active;
    logic                 w_done;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .i_push    (i_TX_DV),
        .i_wr_data (i_PARALLEL_DATA),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (o_FIFO_COUNT)
    );

    assign w_bit_end   = (r_cycle_cnt == c_CYC_LAST);
    assign w_last_stop = r_two_stop ? (r_bit_cnt == BIT_W'(1)) : (r_bit_cnt == '0);
    assign w_par_en    = (r_par_mode == PARITY_EVEN) || (r_par_mode == PARITY_ODD);
    assign w_par_bit   = (^r_data) ^ (r_par_mode == PARITY_ODD);

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) r_state <= c_ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START:  if (w_bit_end) w_next_state = c_ST_DATA;
            c_ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_DATA_LAST))
                    w_next_state = w_par_en ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: if (w_bit_end) w_next_state = c_ST_STOP;
            c_ST_STOP:   if (w_bit_end && w_last_stop) w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_serial = 1'b1;
        w_active = 1'b1;
        w_done   = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_active = 1'b0;
            c_ST_START:  w_serial = 1'b0;
            c_ST_DATA:   w_serial = r_data[r_bit_cnt];
            c_ST_PARITY: w_serial = w_par_bit;
            c_ST_STOP:   w_done   = w_bit_end && w_last_stop;
            default:     w_active = 1'b0;
        endcase
    end

    // Line outputs are registered one cycle behind the state, giving the
    // two-edge latency from accept to start bit.
    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
            r_data      <= '0;
            r_par_mode  <= PARITY_NONE;
            r_two_stop  <= 1'b0;
            r_serial    <= 1'b1;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) || w_bit_end) r_cycle_cnt <= '0;
            else                                     r_cycle_cnt <= r_cycle_cnt + 1'b1;

            if (w_next_state != r_state) r_bit_cnt <= '0;
            else if (w_bit_end)          r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_pop) begin
                r_data     <= w_fifo_head;
                r_par_mode <= i_PARITY_MODE;
                r_two_stop <= i_TWO_STOP;
            end

            r_serial <= w_serial;
            r_active <= w_active;
            r_done   <= w_done;
        end
    end

    assign o_TX_READY    = !w_fifo_full;
    assign o_SERIAL_DATA = r_serial;
    assign o_TX_ACTIVE   = r_active;
    assign o_TX_DONE     = r_done;

endmodule

`default_nettype wire
